// File: rtl/pc_sequencer.sv
// Next-PC controller: owns the fetch PC, arbitrates stalls against ID-stage redirects,
// drives IF/ID write/flush and counts taken redirects. Define JR_EN to decode jr_i.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_i,
    input  logic             branch_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             jr_i,
    input  logic [15:0]      imm_i,
    input  logic [25:0]      jaddr_i,
    input  logic [31:0]      rs_data_i,
    input  logic [31:0]      id_pc4_i,
    output logic [31:0]      pc_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic [CNT_W-1:0] redirect_cnt_o
);

    typedef enum logic [1:0] {
        RUN   = 2'b00,
        STALL = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             jr_sel;
    logic             redirect;
    logic             accept;
    logic [31:0]      target;
    logic [31:0]      pc_next;
    logic [CNT_W-1:0] cnt_next;
    logic             unused_rs_low;

    assign unused_rs_low = ^rs_data_i[1:0];

`ifdef JR_EN
    assign jr_sel = jr_i;
`else
    logic unused_jr;
    assign unused_jr = jr_i;
    assign jr_sel    = 1'b0;
`endif

    assign redirect = jr_sel | jump_i | (branch_i & branch_taken_i);
    // The FLUSH cycle sees the bubble in ID, so its redirect inputs are stale.
    assign accept   = redirect & ~stall_i & (state != FLUSH);

    assign ifid_write_o = ~rst_n | ~stall_i;
    assign ifid_flush_o = rst_n & accept;

    always_comb begin
        target = id_pc4_i + {{14{imm_i[15]}}, imm_i, 2'b00};
        if (jr_sel) begin
            target = {rs_data_i[31:2], 2'b00};
        end else if (jump_i) begin
            target = {id_pc4_i[31:28], jaddr_i, 2'b00};
        end
    end

    always_comb begin
        pc_next    = pc_o + 32'd4;
        state_next = RUN;
        cnt_next   = redirect_cnt_o;
        if (stall_i) begin
            pc_next    = pc_o;
            state_next = STALL;
        end else if (accept) begin
            pc_next    = target;
            state_next = FLUSH;
            if (redirect_cnt_o != {CNT_W{1'b1}}) begin
                cnt_next = redirect_cnt_o + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= RUN;
            pc_o           <= RESET_PC;
            redirect_cnt_o <= '0;
        end else begin
            state          <= state_next;
            pc_o           <= pc_next;
            redirect_cnt_o <= cnt_next;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: directed cases from the block's contract plus
// randomized traffic, checked against a cycle-level reference model.
module tb_pc_sequencer;
    localparam logic [31:0] TB_RESET_PC = 32'h0040_0000;
    localparam int          TB_CNT_W    = 2;
    localparam int          CNT_MAX     = (1 << TB_CNT_W) - 1;
    localparam int          W           = 32 + TB_CNT_W + 2;
`ifdef JR_EN
    localparam bit JR_MODEL = 1'b1;
`else
    localparam bit JR_MODEL = 1'b0;
`endif

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                stall_i = 1'b0, branch_i = 1'b0, branch_taken_i = 1'b0;
    logic                jump_i = 1'b0, jr_i = 1'b0;
    logic [15:0]         imm_i = '0;
    logic [25:0]         jaddr_i = '0;
    logic [31:0]         rs_data_i = '0, id_pc4_i = '0;
    logic [31:0]         pc_o;
    logic                ifid_write_o, ifid_flush_o;
    logic [TB_CNT_W-1:0] redirect_cnt_o;

    logic [W-1:0] exp_q[$];
    int           n_tests = 0;
    int           n_fail  = 0;

    // reference model state
    logic [31:0] m_pc;
    int          m_cnt;
    bit          m_in_flush;

    pc_sequencer #(.RESET_PC(TB_RESET_PC), .CNT_W(TB_CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .stall_i(stall_i), .branch_i(branch_i),
        .branch_taken_i(branch_taken_i), .jump_i(jump_i), .jr_i(jr_i),
        .imm_i(imm_i), .jaddr_i(jaddr_i), .rs_data_i(rs_data_i), .id_pc4_i(id_pc4_i),
        .pc_o(pc_o), .ifid_write_o(ifid_write_o), .ifid_flush_o(ifid_flush_o),
        .redirect_cnt_o(redirect_cnt_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_target(input bit jr, input bit jmp,
        input logic [15:0] imm, input logic [25:0] ja, input logic [31:0] rs,
        input logic [31:0] pc4);
        int simm;
        if (JR_MODEL && jr) return rs & ~32'd3;
        if (jmp) return (pc4 & 32'hF000_0000) | (32'(ja) * 32'd4);
        simm = $signed(imm);
        return pc4 + 32'(simm * 4);
    endfunction

    // One clock cycle: entered and left at posedge+1.
    task automatic drive(input bit rst, input bit stall, input bit br, input bit tk,
        input bit jmp, input bit jr, input logic [15:0] imm, input logic [25:0] ja,
        input logic [31:0] rs, input logic [31:0] pc4);
        bit redir, acc;
        rst_n = ~rst; stall_i = stall; branch_i = br; branch_taken_i = tk;
        jump_i = jmp; jr_i = jr; imm_i = imm; jaddr_i = ja; rs_data_i = rs; id_pc4_i = pc4;
        if (rst) begin
            exp_q.push_back({m_pc, TB_CNT_W'(m_cnt), 1'b1, 1'b0});
            m_pc = TB_RESET_PC; m_cnt = 0; m_in_flush = 1'b0;
        end else begin
            redir = jmp | (br & tk) | (JR_MODEL & jr);
            acc   = redir && !stall && !m_in_flush;
            exp_q.push_back({m_pc, TB_CNT_W'(m_cnt), !stall, acc});
            if (acc) m_pc = ref_target(jr, jmp, imm, ja, rs, pc4);
            else if (!stall) m_pc = m_pc + 32'd4;
            if (acc && m_cnt < CNT_MAX) m_cnt++;
            m_in_flush = acc;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // monitor: the DUT presents one set of outputs per cycle
    initial begin
        logic [W-1:0] e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc_o", pc_o, e[W-1 -: 32]);
                check("redirect_cnt_o", 32'(redirect_cnt_o), 32'(e[TB_CNT_W+1:2]));
                check("ifid_write_o", 32'(ifid_write_o), 32'(e[1]));
                check("ifid_flush_o", 32'(ifid_flush_o), 32'(e[0]));
            end
        end
    end

    initial begin
        int waited;
        repeat (2) @(posedge clk);
        #1;
        m_pc = TB_RESET_PC; m_cnt = 0; m_in_flush = 1'b0;

        idle(3);
        drive(0, 0, 1, 1, 0, 0, 16'hFFFE, 26'h0, 32'h0, 32'h0000_0100);   // -> 0xF8
        drive(0, 0, 1, 1, 0, 0, 16'h0010, 26'h0, 32'h0, 32'h0000_0200);   // ignored in flush
        idle(1);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 26'h40, 32'h0, 32'hA000_0010);     // -> 0xA0000100
        drive(0, 0, 1, 1, 0, 0, 16'h0004, 26'h0, 32'h0, 32'h0000_0300);   // ignored in flush
        drive(0, 1, 1, 1, 0, 0, 16'h0008, 26'h0, 32'h0, 32'h0000_0400);   // stall 1
        drive(0, 1, 1, 1, 0, 0, 16'h0008, 26'h0, 32'h0, 32'h0000_0400);   // stall 2
        drive(0, 0, 1, 1, 0, 0, 16'h0008, 26'h0, 32'h0, 32'h0000_0400);   // accepted
        idle(1);
        drive(0, 0, 0, 0, 1, 0, 16'h0, 26'h3FF_FFFF, 32'h0, 32'hF000_0000); // -> 0xFFFFFFFC
        idle(2);                                                           // wraps to 0
        drive(0, 0, 0, 0, 1, 0, 16'h0, 26'h100, 32'h0, 32'h0000_0000);
        drive(0, 1, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);               // stall in FLUSH
        drive(0, 0, 1, 1, 0, 0, 16'h0002, 26'h0, 32'h0, 32'h0000_1000);   // saturating count
        drive(0, 0, 0, 0, 0, 0, 16'h0, 26'h0, 32'h0, 32'h0);
        drive(0, 1, 0, 0, 1, 0, 16'h0, 26'h55, 32'h0, 32'h0);              // stall + redirect
        drive(0, 0, 1, 1, 1, 1, 16'h0004, 26'h80, 32'h0000_1237, 32'h0000_0500); // jr/jump/br
        idle(1);
        drive(1, 1, 1, 1, 1, 0, 16'h0, 26'h33, 32'h0, 32'h0);              // mid-op reset
        drive(1, 0, 0, 0, 1, 0, 16'h0, 26'h33, 32'h0, 32'h0);
        idle(2);

        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0,
                  16'($urandom), 26'($urandom), $urandom, $urandom);
        end
        idle(1);

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        n_tests++;
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
